// File: rtl/comp_sort_ctrl.sv
// Burst sorter: loads DEPTH unsigned values, bubble-sorts them with a single
// shared magnitude comparator (one compare-and-swap per clock), then streams them out ascending.
module comp_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       swap_cnt
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_STEP = PW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg, pass_reg, step_reg;
  logic [7:0]       swap_cnt_reg;

  logic             accept, pop, sort_done;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             a_gt_b;
  logic [PW-1:0]    step_plus1;

  // The one shared comparator; only A>B matters, so equal values never swap.
  assign step_plus1 = step_reg + 1'b1;
  assign cmp_a      = mem_reg[step_reg];
  assign cmp_b      = mem_reg[step_plus1];
  assign a_gt_b     = cmp_a > cmp_b;

  assign swap_cnt = swap_cnt_reg;
  assign out_data = out_valid ? mem_reg[rd_ptr_reg] : '0;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    pop        = 1'b0;
    sort_done  = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && wr_ptr_reg == LAST_IDX) state_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (pass_reg == LAST_STEP && step_reg == LAST_STEP) begin
          sort_done  = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = (rd_ptr_reg == LAST_IDX);
        pop       = out_ready;
        if (out_ready && out_last) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pass_reg     <= '0;
      step_reg     <= '0;
      swap_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        mem_reg[wr_ptr_reg] <= in_data;
        if (wr_ptr_reg == LAST_IDX) begin
          wr_ptr_reg   <= '0;
          swap_cnt_reg <= '0;
          pass_reg     <= '0;
          step_reg     <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
      end

      if (busy) begin
        if (a_gt_b) begin
          mem_reg[step_reg]   <= cmp_b;
          mem_reg[step_plus1] <= cmp_a;
          if (swap_cnt_reg != 8'hFF) swap_cnt_reg <= swap_cnt_reg + 8'd1;
        end
        if (step_reg == LAST_STEP) begin
          step_reg <= '0;
          pass_reg <= sort_done ? '0 : pass_reg + 1'b1;
        end else begin
          step_reg <= step_plus1;
        end
        if (sort_done) rd_ptr_reg <= '0;
      end

      if (pop) rd_ptr_reg <= out_last ? '0 : rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_comp_sort_ctrl.sv
// Self-checking bench for comp_sort_ctrl: directed burst table, hold/gap/reset
// corner sequences, then random bursts checked against a sort + inversion-count model.
module tb_comp_sort_ctrl;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int SORT_CYCLES = (DEPTH - 1) * (DEPTH - 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [7:0]       swap_cnt;

  int checks = 0;
  int errors = 0;

  comp_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  // Element 0 sits in the rightmost nibble of each packed vector.
  typedef struct {
    logic [DEPTH-1:0][WIDTH-1:0] din;
    logic [DEPTH-1:0][WIDTH-1:0] dout;
    int                          swaps;
    int                          gap;
    int                          hold_idx;
    int                          hold_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_burst(input logic [DEPTH-1:0][WIDTH-1:0] v, input int gap);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gap_in_ready", in_ready, 1);
        chk("gap_busy", busy, 0);
      end
      chk("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[i];
      @(posedge clk); #1;
      $display("load[%0d] = %0h", i, v[i]);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Called #1 after the last accepting edge; measures SORT length then drains outputs.
  task automatic drain_burst(input logic [DEPTH-1:0][WIDTH-1:0] exp, input int exp_swaps,
                             input int hold_idx, input int hold_cyc);
    int n;
    n = 0;
    in_valid = 1'b1;  // must be ignored while sorting
    while (busy && n < 50) begin
      chk("sort_in_ready", in_ready, 0);
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("busy_cycles", n, SORT_CYCLES);
    chk("swap_cnt", swap_cnt, exp_swaps);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == hold_idx && hold_cyc > 0) begin
        out_ready = 1'b0;
        for (int h = 0; h < hold_cyc; h++) begin
          @(posedge clk); #1;
          chk("hold_out_data", out_data, exp[i]);
          chk("hold_out_valid", out_valid, 1);
          chk("hold_out_last", out_last, (i == DEPTH - 1));
        end
        out_ready = 1'b1;
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp[i]);
      chk("out_last", out_last, (i == DEPTH - 1));
      chk("out_swap_cnt", swap_cnt, exp_swaps);
      $display("out[%0d] = %0h last=%0b swaps=%0d", i, out_data, out_last, swap_cnt);
      @(posedge clk); #1;
    end
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  // Reference: ascending order by sort, swap count as number of inversions.
  task automatic model(input logic [DEPTH-1:0][WIDTH-1:0] v,
                       output logic [DEPTH-1:0][WIDTH-1:0] sorted, output int swaps);
    int q[$];
    swaps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(int'(v[i]));
      for (int j = i + 1; j < DEPTH; j++) if (v[i] > v[j]) swaps++;
    end
    q.sort();
    for (int i = 0; i < DEPTH; i++) sorted[i] = WIDTH'(q[i]);
    if (swaps > 255) swaps = 255;
  endtask

  vec_t tbl [6];

  initial begin
    logic [DEPTH-1:0][WIDTH-1:0] rv, rs;
    int rsw;

    tbl[0] = '{din: {4'h7, 4'h9, 4'h2, 4'hC}, dout: {4'hC, 4'h9, 4'h7, 4'h2}, swaps: 4, gap: 0, hold_idx: -1, hold_cyc: 0};
    tbl[1] = '{din: {4'h4, 4'h3, 4'h2, 4'h1}, dout: {4'h4, 4'h3, 4'h2, 4'h1}, swaps: 0, gap: 0, hold_idx: -1, hold_cyc: 0};
    tbl[2] = '{din: {4'hC, 4'hD, 4'hE, 4'hF}, dout: {4'hF, 4'hE, 4'hD, 4'hC}, swaps: 6, gap: 0, hold_idx: -1, hold_cyc: 0};
    tbl[3] = '{din: {4'hF, 4'h0, 4'hF, 4'h0}, dout: {4'hF, 4'hF, 4'h0, 4'h0}, swaps: 1, gap: 0, hold_idx: -1, hold_cyc: 0};
    tbl[4] = '{din: {4'h9, 4'h9, 4'h9, 4'h9}, dout: {4'h9, 4'h9, 4'h9, 4'h9}, swaps: 0, gap: 3, hold_idx: -1, hold_cyc: 0};
    tbl[5] = '{din: {4'h7, 4'h9, 4'h2, 4'hC}, dout: {4'hC, 4'h9, 4'h7, 4'h2}, swaps: 4, gap: 0, hold_idx: 1, hold_cyc: 5};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_swap_cnt", swap_cnt, 0);

    for (int t = 0; t < 6; t++) begin
      $display("burst %0d", t);
      load_burst(tbl[t].din, tbl[t].gap);
      drain_burst(tbl[t].dout, tbl[t].swaps, tbl[t].hold_idx, tbl[t].hold_cyc);
    end

    // Reset during SORT abandons the burst.
    load_burst({4'h7, 4'h9, 4'h2, 4'hC}, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midsort_rst_in_ready", in_ready, 1);
    chk("midsort_rst_busy", busy, 0);
    chk("midsort_rst_swap_cnt", swap_cnt, 0);
    chk("midsort_rst_out_valid", out_valid, 0);
    load_burst({4'h0, 4'h2, 4'h1, 4'h3}, 0);
    drain_burst({4'h3, 4'h2, 4'h1, 4'h0}, 5, -1, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) rv[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      model(rv, rs, rsw);
      $display("random burst %0d", r);
      load_burst(rv, int'($urandom_range(0, 2)));
      drain_burst(rs, rsw, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_sort_ctrl.md
Name: comp_sort_ctrl

Overview:
- Sequencer that time-shares one WIDTH-bit magnitude comparator (A>B, A<B, A==B semantics, unsigned) to sort a burst of DEPTH values ascending.
- Three phases: loads values over a valid/ready input stream, runs a fixed-length bubble-sort schedule with one compare-and-swap per clock, then streams the sorted values out with a valid/ready handshake.
- Sits between a data producer and consumer; exercises the comparator as a shared sequential resource.

Parameters:
WIDTH, 4, bit width of each unsigned element
DEPTH, 4, elements per burst (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  producer has in_data
in_data  input  WIDTH  element to load
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  out_data is a sorted element
out_data  output  WIDTH  sorted element, ascending order
out_ready  input  1  consumer accepts out_data this cycle
out_last  output  1  qualifies the final (largest) element of the burst
busy  output  1  high in SORT state
swap_cnt  output  8  swaps performed in the current burst, saturating at 255

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - State goes to LOAD; wr_ptr, rd_ptr, pass/step counters and swap_cnt all go to 0; element storage is cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, swap_cnt=0.
  - Reset mid-LOAD, mid-SORT or mid-OUT abandons the burst. No partial output.
- States: LOAD, SORT, OUT.
- LOAD:
  - in_ready=1.
  - Accept occurs when in_valid and in_ready are both 1: mem[wr_ptr] <= in_data, wr_ptr increments.
  - The accept with wr_ptr==DEPTH-1 moves to SORT next cycle and zeroes wr_ptr and swap_cnt.
  - in_valid=0 holds state.
- SORT:
  - in_ready=0, busy=1.
  - Fixed schedule of (DEPTH-1) passes x (DEPTH-1) steps = 9 cycles at default. No early exit; latency is data-independent.
  - Step j in 0..DEPTH-2 compares A=mem[j], B=mem[j+1].
  - If A>B: swap the pair in that same edge and increment swap_cnt (saturating).
  - If A<B or A==B: no swap, so equal values keep their order.
  - After the last step of the last pass, go to OUT with rd_ptr=0.
- OUT:
  - out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==DEPTH-1).
  - On out_valid and out_ready both 1, rd_ptr increments.
  - The handshake with out_last=1 returns to LOAD: in_ready=1 and out_valid=0 the next cycle.
  - out_ready=0 holds out_data and out_last stable.
  - swap_cnt stays stable through OUT and is cleared at the next SORT entry.
- Timing:
  - Last input accepted at edge t.
  - busy is high for the 9 cycles after t.
  - out_valid rises after edge t+9.
  - Minimum burst turnaround is DEPTH + 9 + DEPTH cycles.
- Arithmetic: unsigned compare only. Values 0 and 2^WIDTH-1 must sort correctly. No wrap on pointers beyond DEPTH-1; each pointer resets to 0 at its phase exit.
- Simultaneous events:
  - in_valid asserted outside LOAD is ignored.
  - out_ready asserted outside OUT is ignored.
  - rst_n=0 overrides all other inputs.

Test Plan:
- Load C,2,9,7 -> busy for 9 cycles; outputs 2,7,9,C; out_last only with C; swap_cnt=4.
- Load 1,2,3,4 (sorted) -> outputs 1,2,3,4; swap_cnt=0; still 9 SORT cycles.
- Load F,E,D,C, then 0,F,0,F -> first burst outputs C,D,E,F with swap_cnt=6. Second burst outputs 0,0,F,F with swap_cnt=1, confirming extremes and swap_cnt clear between bursts.
- Load 9,9,9,9 -> outputs 9,9,9,9; swap_cnt=0. Then gaps: drop in_valid for 3 cycles between elements -> same result; wr_ptr holds.
- In OUT, hold out_ready=0 for 5 cycles on the second element -> out_data stays 7 with out_valid=1; release -> remaining 9,C follow one per cycle.
- Assert rst_n=0 for one cycle during SORT step 4 -> next cycle LOAD, in_ready=1, busy=0, swap_cnt=0. A fresh burst 3,1,2,0 then outputs 0,1,2,3.
